// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit:
// forward-select encodings, hazard FSM states and the hard-wired zero register.
package fwd_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_EM = 2'b10;
    localparam logic [1:0] FWD_MW = 2'b01;

    localparam int REG_ZERO = 0;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hazState_e;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-register fields consumed by the hazard unit and the controls it drives back.
// slave = the hazard unit, master = the surrounding pipeline.
interface fwd_hazard_unit_if #(
    parameter int REG_AW = 5
);

    logic              ext_hold;
    logic [REG_AW-1:0] IE_RegRs;
    logic [REG_AW-1:0] IE_RegRt;
    logic [REG_AW-1:0] IE_RegRd;
    logic              IE_RegWrite;
    logic              IE_MemRead;
    logic [REG_AW-1:0] ID_RegRs;
    logic [REG_AW-1:0] ID_RegRt;
    logic              ID_valid;
    logic              EM_RegWrite;
    logic [REG_AW-1:0] EM_RegRd;
    logic              MW_RegWrite;
    logic [REG_AW-1:0] MW_RegRd;
    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              stall;
    logic              flush_ie;
    logic              busy;

    modport master (
        output ext_hold, IE_RegRs, IE_RegRt, IE_RegRd, IE_RegWrite, IE_MemRead,
               ID_RegRs, ID_RegRt, ID_valid, EM_RegWrite, EM_RegRd, MW_RegWrite, MW_RegRd,
        input  ForwardA, ForwardB, stall, flush_ie, busy
    );

    modport slave (
        input  ext_hold, IE_RegRs, IE_RegRt, IE_RegRd, IE_RegWrite, IE_MemRead,
               ID_RegRs, ID_RegRt, ID_valid, EM_RegWrite, EM_RegRd, MW_RegWrite, MW_RegRd,
        output ForwardA, ForwardB, stall, flush_ie, busy
    );

endinterface

// File: rtl/fwd_select.sv
// Per-operand forward-select: EX/MEM beats MEM/WB, register 0 never forwards,
// and everything collapses to the register-file path while initi is high.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              initi,
    input  logic [REG_AW-1:0] ieReg,
    input  logic              emRegWrite,
    input  logic [REG_AW-1:0] emRegRd,
    input  logic              mwRegWrite,
    input  logic [REG_AW-1:0] mwRegRd,
    output logic [1:0]        fwdSel
);

    always_comb begin
        fwdSel = FWD_RF;
        if (!initi) begin
            if (emRegWrite && (emRegRd != REG_AW'(REG_ZERO)) && (emRegRd == ieReg)) begin
                fwdSel = FWD_EM;
            end else if (mwRegWrite && (mwRegRd != REG_AW'(REG_ZERO)) && (mwRegRd == ieReg)) begin
                fwdSel = FWD_MW;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding plus a load-use stall FSM inserting LOAD_LAT bubbles.
// Optional FWD_STATS_EN adds saturating stall / forward cycle counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 3
) (
    input  logic               clk,
    input  logic               initi,
    fwd_hazard_unit_if.slave   pif
`ifdef FWD_STATS_EN
    ,
    output logic [15:0]        stat_stalls,
    output logic [15:0]        stat_fwds
`endif
);

    hazState_e        state;
    hazState_e        nextState;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             haz;
    logic             stallInt;
    logic             flushInt;
    logic [1:0]       fwdA;
    logic [1:0]       fwdB;

    fwd_select #(.REG_AW(REG_AW)) u_fwdA (
        .initi      (initi),
        .ieReg      (pif.IE_RegRs),
        .emRegWrite (pif.EM_RegWrite),
        .emRegRd    (pif.EM_RegRd),
        .mwRegWrite (pif.MW_RegWrite),
        .mwRegRd    (pif.MW_RegRd),
        .fwdSel     (fwdA)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwdB (
        .initi      (initi),
        .ieReg      (pif.IE_RegRt),
        .emRegWrite (pif.EM_RegWrite),
        .emRegRd    (pif.EM_RegRd),
        .mwRegWrite (pif.MW_RegWrite),
        .mwRegRd    (pif.MW_RegRd),
        .fwdSel     (fwdB)
    );

    assign haz = pif.ID_valid && pif.IE_MemRead && pif.IE_RegWrite &&
                 (pif.IE_RegRd != REG_AW'(REG_ZERO)) &&
                 ((pif.IE_RegRd == pif.ID_RegRs) || (pif.IE_RegRd == pif.ID_RegRt));

    always_ff @(posedge clk or posedge initi) begin
        if (initi) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= cntNext;
        end
    end

    // With LOAD_LAT == 1 the single bubble comes from IDLE itself; the FSM only
    // walks through STALL for the remaining LOAD_LAT-1 cycles.
    always_comb begin
        nextState = state;
        cntNext   = cnt;
        if (!pif.ext_hold) begin
            case (state)
                IDLE: begin
                    if (haz && (LOAD_LAT > 1)) begin
                        nextState = STALL;
                        cntNext   = CNT_W'(LOAD_LAT - 1);
                    end
                end
                STALL: begin
                    if (cnt == CNT_W'(1)) begin
                        nextState = IDLE;
                        cntNext   = '0;
                    end else begin
                        cntNext = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    nextState = IDLE;
                    cntNext   = '0;
                end
            endcase
        end
    end

    assign stallInt = !initi && (((state == IDLE) && haz) || (state == STALL));
    assign flushInt = stallInt && !pif.ext_hold;

    assign pif.ForwardA = fwdA;
    assign pif.ForwardB = fwdB;
    assign pif.stall    = stallInt;
    assign pif.flush_ie = flushInt;
    assign pif.busy     = (state == STALL);

`ifdef FWD_STATS_EN
    always_ff @(posedge clk or posedge initi) begin
        if (initi) begin
            stat_stalls <= '0;
            stat_fwds   <= '0;
        end else begin
            if (flushInt && (stat_stalls != 16'hFFFF)) begin
                stat_stalls <= stat_stalls + 16'd1;
            end
            if (((fwdA != FWD_RF) || (fwdB != FWD_RF)) && (stat_fwds != 16'hFFFF)) begin
                stat_fwds <= stat_fwds + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: three instances (LOAD_LAT 1, 3, 4) share one stimulus
// stream and are compared each cycle against a bubbles-owed reference model.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic initi;
  always #5 clk = ~clk;

  logic       ext_hold;
  logic [4:0] ie_rs, ie_rt, ie_rd, id_rs, id_rt, em_rd, mw_rd;
  logic       ie_reg_write, ie_mem_read, id_valid, em_reg_write, mw_reg_write;

  logic [1:0] fwd_a_v [3];
  logic [1:0] fwd_b_v [3];
  logic       stall_v [3];
  logic       flush_v [3];
  logic       busy_v  [3];
`ifdef FWD_STATS_EN
  logic [15:0] stat_s_v [3];
  logic [15:0] stat_f_v [3];
  int          m_stalls [3];
  int          m_fwds   [3];
`endif

  int n_checks = 0;
  int n_errors = 0;
  int lat [3] = '{1, 3, 4};
  int rem [3];          // bubbles still owed by each instance
  int flush_seen [3];
  int busy_seen  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    fwd_hazard_unit_if #(.REG_AW(5)) pif ();
    assign pif.ext_hold    = ext_hold;
    assign pif.IE_RegRs    = ie_rs;
    assign pif.IE_RegRt    = ie_rt;
    assign pif.IE_RegRd    = ie_rd;
    assign pif.IE_RegWrite = ie_reg_write;
    assign pif.IE_MemRead  = ie_mem_read;
    assign pif.ID_RegRs    = id_rs;
    assign pif.ID_RegRt    = id_rt;
    assign pif.ID_valid    = id_valid;
    assign pif.EM_RegWrite = em_reg_write;
    assign pif.EM_RegRd    = em_rd;
    assign pif.MW_RegWrite = mw_reg_write;
    assign pif.MW_RegRd    = mw_rd;
    assign fwd_a_v[g] = pif.ForwardA;
    assign fwd_b_v[g] = pif.ForwardB;
    assign stall_v[g] = pif.stall;
    assign flush_v[g] = pif.flush_ie;
    assign busy_v[g]  = pif.busy;

    fwd_hazard_unit #(.REG_AW(5), .LOAD_LAT(LAT), .CNT_W(3)) dut (
      .clk   (clk),
      .initi (initi),
      .pif   (pif)
`ifdef FWD_STATS_EN
      ,
      .stat_stalls (stat_s_v[g]),
      .stat_fwds   (stat_f_v[g])
`endif
    );
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (initi) return 2'b00;
    if (em_reg_write && em_rd != 0 && em_rd == src) return 2'b10;
    if (mw_reg_write && mw_rd != 0 && mw_rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic haz_now();
    return id_valid && ie_mem_read && ie_reg_write && ie_rd != 0 &&
           (ie_rd == id_rs || ie_rd == id_rt);
  endfunction

  task automatic check_cycle();
    for (int g = 0; g < 3; g++) begin
      logic es;
      logic ef;
      logic eb;
      es = !initi && (rem[g] > 0 || haz_now());
      ef = es && !ext_hold;
      eb = !initi && rem[g] > 0;
      check_val($sformatf("fwdA_L%0d", lat[g]), 32'(fwd_a_v[g]), 32'(exp_fwd(ie_rs)));
      check_val($sformatf("fwdB_L%0d", lat[g]), 32'(fwd_b_v[g]), 32'(exp_fwd(ie_rt)));
      check_val($sformatf("stall_L%0d", lat[g]), 32'(stall_v[g]), 32'(es));
      check_val($sformatf("flush_L%0d", lat[g]), 32'(flush_v[g]), 32'(ef));
      check_val($sformatf("busy_L%0d", lat[g]), 32'(busy_v[g]), 32'(eb));
`ifdef FWD_STATS_EN
      check_val($sformatf("statStalls_L%0d", lat[g]), 32'(stat_s_v[g]), 32'(m_stalls[g]));
      check_val($sformatf("statFwds_L%0d", lat[g]), 32'(stat_f_v[g]), 32'(m_fwds[g]));
`endif
      flush_seen[g] += int'(flush_v[g]);
      busy_seen[g]  += int'(busy_v[g]);
    end
  endtask

  task automatic clear_model();
    for (int g = 0; g < 3; g++) begin
      rem[g] = 0;
`ifdef FWD_STATS_EN
      m_stalls[g] = 0;
      m_fwds[g]   = 0;
`endif
    end
  endtask

  task automatic advance_model();
    if (initi) begin
      clear_model();
    end else begin
      for (int g = 0; g < 3; g++) begin
`ifdef FWD_STATS_EN
        if ((rem[g] > 0 || haz_now()) && !ext_hold && m_stalls[g] < 65535) m_stalls[g]++;
        if ((exp_fwd(ie_rs) != 0 || exp_fwd(ie_rt) != 0) && m_fwds[g] < 65535) m_fwds[g]++;
`endif
        if (!ext_hold) begin
          if (rem[g] > 0) rem[g]--;
          else if (haz_now()) rem[g] = lat[g] - 1;
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_cycle();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  // Reset asserted and released between edges: only an asynchronous reset clears busy.
  task automatic reset_pulse();
    initi = 1'b1;
    #1;
    check_cycle();
    clear_model();
    initi = 1'b0;
    #1;
    check_cycle();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  task automatic set_quiet();
    ext_hold = 0; ie_rs = 0; ie_rt = 0; ie_rd = 0; id_rs = 0; id_rt = 0;
    em_rd = 0; mw_rd = 0; ie_reg_write = 0; ie_mem_read = 0; id_valid = 0;
    em_reg_write = 0; mw_reg_write = 0;
  endtask

  task automatic clear_seen();
    for (int g = 0; g < 3; g++) begin
      flush_seen[g] = 0;
      busy_seen[g]  = 0;
    end
  endtask

  task automatic set_load_hazard();
    id_valid = 1; ie_mem_read = 1; ie_reg_write = 1; ie_rd = 8; id_rt = 8; id_rs = 3;
  endtask

  initial begin
    initi = 1'b1;
    set_quiet();
    clear_model();
    clear_seen();
    // Reset with matching forward sources and a live hazard: everything must read 0.
    em_reg_write = 1; em_rd = 5; mw_reg_write = 1; mw_rd = 6; ie_rs = 5; ie_rt = 6;
    set_load_hazard();
    cycle();
    check_val("rst_fwdA", 32'(fwd_a_v[0]), 32'd0);
    check_val("rst_stall", 32'(stall_v[2]), 32'd0);
    cycle();
    initi = 1'b0;
    set_quiet();

    em_reg_write = 1; em_rd = 5; mw_reg_write = 1; mw_rd = 5; ie_rs = 5;
    cycle();
    check_val("tp_fwdA_em", 32'(fwd_a_v[0]), 32'h2);
    em_reg_write = 0;
    cycle();
    check_val("tp_fwdA_mw", 32'(fwd_a_v[0]), 32'h1);
    em_reg_write = 1; em_rd = 0; mw_reg_write = 0; ie_rt = 0;
    cycle();
    check_val("tp_fwdB_r0", 32'(fwd_b_v[0]), 32'h0);
    set_quiet();
    cycle();

    // One load-use hazard, then ID/EX carries bubbles.
    clear_seen();
    set_load_hazard();
    cycle();
    set_quiet();
    repeat (5) cycle();
    check_val("tp_flushes_L1", 32'(flush_seen[0]), 32'd1);
    check_val("tp_busy_L1", 32'(busy_seen[0]), 32'd0);
    check_val("tp_flushes_L3", 32'(flush_seen[1]), 32'd3);
    check_val("tp_busy_L3", 32'(busy_seen[1]), 32'd2);
    check_val("tp_flushes_L4", 32'(flush_seen[2]), 32'd4);

    // Same hazard with a two-cycle hold in the middle of the stall.
    clear_seen();
    set_load_hazard();
    cycle();
    set_quiet();
    ext_hold = 1;
    repeat (2) cycle();
    ext_hold = 0;
    repeat (5) cycle();
    check_val("tp_hold_flushes_L3", 32'(flush_seen[1]), 32'd3);
    check_val("tp_hold_busy_L3", 32'(busy_seen[1]), 32'd4);
    check_val("tp_hold_flushes_L4", 32'(flush_seen[2]), 32'd4);

    // Reset in the second stall cycle of LOAD_LAT=4; no bubble is owed afterwards.
    set_load_hazard();
    cycle();
    set_quiet();
    #1;
    check_val("tp_mid_busy_L4", 32'(busy_v[2]), 32'd1);
    reset_pulse();
    clear_seen();
    repeat (4) cycle();
    check_val("tp_post_rst_busy_L4", 32'(busy_seen[2]), 32'd0);
    check_val("tp_post_rst_flush_L4", 32'(flush_seen[2]), 32'd0);

    // Random traffic over a small register window so matches are frequent.
    repeat (600) begin
      ie_rs = 5'($urandom_range(0, 3));
      ie_rt = 5'($urandom_range(0, 3));
      ie_rd = 5'($urandom_range(0, 3));
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      em_rd = 5'($urandom_range(0, 3));
      mw_rd = 5'($urandom_range(0, 3));
      ie_reg_write = 1'($urandom_range(0, 1));
      ie_mem_read  = 1'($urandom_range(0, 1));
      id_valid     = ($urandom_range(0, 9) < 7);
      em_reg_write = 1'($urandom_range(0, 1));
      mw_reg_write = 1'($urandom_range(0, 1));
      ext_hold     = ($urandom_range(0, 9) < 2);
      if ($urandom_range(0, 99) == 0) reset_pulse();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the EX-stage forwarding unit.
- Combines EX/MEM and MEM/WB operand forwarding with a load-use hazard detector.
- The detector is a small FSM that inserts LOAD_LAT bubble cycles and honours an external pipeline hold.
- Sits between the ID/EX, EX/MEM and MEM/WB pipeline registers. Drives the ALU operand muxes, the PC/IF-ID write enables and the ID/EX bubble control.

Parameters:
- REG_AW, 5: register-address width; register 0 is hard-wired zero.
- LOAD_LAT, 1: bubble cycles per load-use hazard; legal range 1..4.
- CNT_W, 3: width of the internal stall counter; must satisfy 2^CNT_W > LOAD_LAT.

Ports:
- clk  in  1  pipeline clock.
- initi  in  1  asynchronous active-high reset; also forces all forward selects to 00 while high.
- ext_hold  in  1  external pipeline freeze (e.g. memory busy); freezes FSM and counter.
- IE_RegRs  in  REG_AW  ID/EX source 1.
- IE_RegRt  in  REG_AW  ID/EX source 2.
- IE_RegRd  in  REG_AW  ID/EX destination.
- IE_RegWrite  in  1  ID/EX writes a register.
- IE_MemRead  in  1  ID/EX is a load.
- ID_RegRs  in  REG_AW  IF/ID source 1.
- ID_RegRt  in  REG_AW  IF/ID source 2.
- ID_valid  in  1  IF/ID holds a real instruction.
- EM_RegWrite  in  1  EX/MEM writes a register.
- EM_RegRd  in  REG_AW  EX/MEM destination.
- MW_RegWrite  in  1  MEM/WB writes a register.
- MW_RegRd  in  REG_AW  MEM/WB destination.
- ForwardA  out  2  ALU operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- ForwardB  out  2  ALU operand B select, same encoding.
- stall  out  1  hold PC and IF/ID.
- flush_ie  out  1  load a bubble into ID/EX.
- busy  out  1  FSM in STALL state.

Behaviour:
- Reset (initi high, asynchronous):
  - state = IDLE, cnt = 0.
  - ForwardA, ForwardB, stall, flush_ie and busy are all 0 while initi is high.
- Forwarding (combinational, zero latency):
  - ForwardX[1] = EM_RegWrite & (EM_RegRd != 0) & (EM_RegRd == IE_RegRx) & !initi.
  - ForwardX[0] = MW_RegWrite & (MW_RegRd != 0) & (MW_RegRd == IE_RegRx) & !ForwardX[1] & !initi.
  - EX/MEM has priority, so 11 is never produced.
  - Register 0 never forwards.
- Hazard term: haz = ID_valid & IE_MemRead & IE_RegWrite & (IE_RegRd != 0) & (IE_RegRd == ID_RegRs | IE_RegRd == ID_RegRt).
- Output equations:
  - stall = (IDLE & haz) | STALL.
  - flush_ie = stall & !ext_hold. During a hold, ID/EX is frozen by its owner, not flushed.
  - busy = STALL.
- FSM states: IDLE, STALL.
  - IDLE, haz & !ext_hold, LOAD_LAT == 1: remain IDLE. One bubble is issued. Next cycle IE holds the bubble, so haz drops.
  - IDLE, haz & !ext_hold, LOAD_LAT > 1: go to STALL with cnt = LOAD_LAT - 1.
  - STALL, !ext_hold: cnt decrements. When cnt == 1, go to IDLE with cnt = 0.
  - Total stall cycles per hazard = LOAD_LAT, excluding hold cycles.
  - Any state, ext_hold: state and cnt unchanged. stall still reflects its equation.
  - STALL ignores new haz evaluation. IE contains bubbles, so no retrigger is needed.
- Reset mid-STALL: immediate return to IDLE. The stall sequence is abandoned and no bubble is owed.
- Width rule: cnt is CNT_W bits and never wraps; it is loaded only from LOAD_LAT - 1.

Optional Feature:
- Macro: FWD_STATS_EN.
- When defined:
  - Adds outputs stat_stalls and stat_fwds, each 16-bit.
  - stat_stalls counts cycles with flush_ie = 1.
  - stat_fwds counts cycles where ForwardA != 00 or ForwardB != 00, counted once per cycle.
  - Both counters saturate at 16'hFFFF and clear on initi.
  - A count increments at the clock edge following the qualifying cycle.
- When undefined: no counters and no extra ports. All other behaviour is identical.

Decomposition:
- Shared package fwd_pkg holds:
  - forward-select constants FWD_RF = 2'b00, FWD_EM = 2'b10, FWD_MW = 2'b01;
  - the FSM state typedef {IDLE, STALL};
  - REG_ZERO.
- One natural sub-module: fwd_select. It contains the pure-combinational per-operand forwarding logic and is instantiated twice, for A and B.
- The FSM and counter live in the top.

Test Plan:
- EM_RegWrite=1, EM_RegRd=5, MW_RegWrite=1, MW_RegRd=5, IE_RegRs=5 -> ForwardA=10. Same with EM_RegWrite=0 -> ForwardA=01.
- EM_RegRd=0, EM_RegWrite=1, IE_RegRt=0 -> ForwardB=00. Asserting initi with any matching inputs -> all forward selects 00.
- LOAD_LAT=1: IE_MemRead=1, IE_RegWrite=1, IE_RegRd=8, ID_RegRt=8, ID_valid=1 -> stall=1 and flush_ie=1 for exactly 1 cycle, busy stays 0.
- LOAD_LAT=3, same hazard -> stall=1 for 3 cycles. busy=1 in cycles 2-3. Then stall=0.
- LOAD_LAT=3, ext_hold=1 for 2 cycles during STALL -> flush_ie=0 while held. Total flush_ie cycles still 3. cnt frozen.
- LOAD_LAT=4, initi pulsed in the 2nd stall cycle -> stall, busy and flush_ie go 0 asynchronously. With no haz present after release, the FSM stays IDLE.
